game_state_mux: RTL and testbench

- Master-side (player 1 board) framer for the inter-board UART link; the transmit-end counterpart of the slave's game-state demultiplexer.
- Snapshots the authoritative game state: player-1 position, ball position, both scores, point flag and end-game flag.
- Serialises the snapshot as a tagged, checksummed frame of six 16-bit words.
- Feeds the existing 16-to-8 converter / UART transmitter, which runs on the 65 MHz pixel clock domain.

---
 rtl/game_state_mux_pkg.sv | 39 +++
 rtl/game_state_mux_if.sv | 23 ++
 rtl/game_state_mux.sv | 113 +++++++++++
 tb/tb_game_state_mux.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_mux_pkg.sv
// Shared definitions for the inter-board game-state link: frame tags, word count,
// framer states and the layout of the status payload.
package game_state_mux_pkg;

  localparam int FRAME_WORDS = 6;

  localparam logic [3:0] TAG_PL1X  = 4'h1;
  localparam logic [3:0] TAG_PL1Y  = 4'h2;
  localparam logic [3:0] TAG_BALLX = 4'h3;
  localparam logic [3:0] TAG_BALLY = 4'h4;
  localparam logic [3:0] TAG_STAT  = 4'h5;
  localparam logic [3:0] TAG_CSUM  = 4'hF;

  localparam int STAT_FLAG_POINT_BIT = 9;
  localparam int STAT_END_GAME_BIT   = 8;
  localparam int STAT_PL1_SCORE_LSB  = 4;
  localparam int STAT_PL2_SCORE_LSB  = 0;

  typedef enum logic [1:0] {
    GAP  = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2
  } frame_state_t;

  // Bits [11:10] stay zero so the demux side can treat them as reserved.
  function automatic logic [11:0] status_payload(input logic       flag_point,
                                                 input logic       end_game,
                                                 input logic [3:0] pl1_score,
                                                 input logic [3:0] pl2_score);
    logic [11:0] p;
    p = '0;
    p[STAT_FLAG_POINT_BIT]            = flag_point;
    p[STAT_END_GAME_BIT]              = end_game;
    p[STAT_PL1_SCORE_LSB +: 4]        = pl1_score;
    p[STAT_PL2_SCORE_LSB +: 4]        = pl2_score;
    return p;
  endfunction

endpackage

// File: rtl/game_state_mux_if.sv
// Word handshake between the game-state framer and the 16-to-8 converter.
interface game_state_mux_if;

  logic [15:0] data;
  logic        data_valid;
  logic        frame_done;
  logic        conv16to8ready;

  modport master (
    output data,
    output data_valid,
    output frame_done,
    input  conv16to8ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  frame_done,
    output conv16to8ready
  );

endinterface

// File: rtl/game_state_mux.sv
// Master-side framer: snapshots the game state and sends it as six tagged,
// checksummed 16-bit words to the UART converter, one word per ready pulse.
module game_state_mux
  import game_state_mux_pkg::*;
#(
  parameter int FRAME_GAP = 1000
) (
  input  logic        clk,
  input  logic        rst,
  game_state_mux_if.master link,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game
);

  localparam int               GAP_W    = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP);
  localparam logic [2:0]       LAST_IDX = 3'(FRAME_WORDS - 1);

  frame_state_t     state;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       word_idx;

  logic [11:0] snap_pl1_posy;
  logic [11:0] snap_ball_posx;
  logic [11:0] snap_ball_posy;
  logic [11:0] snap_status;
  logic [11:0] csum;

  logic [11:0] live_status;
  logic [11:0] live_sum;
  logic [15:0] next_word;

  // Checksum is taken from the same values that get latched, so the frame is coherent.
  always_comb begin
    live_status = status_payload(flag_point, end_game, pl1_score, pl2_score);
    live_sum    = pl1_posx + pl1_posy + ball_posx + ball_posy + live_status;
  end

  always_comb begin
    next_word = {TAG_CSUM, csum};
    case (word_idx)
      3'd0:    next_word = {TAG_PL1Y,  snap_pl1_posy};
      3'd1:    next_word = {TAG_BALLX, snap_ball_posx};
      3'd2:    next_word = {TAG_BALLY, snap_ball_posy};
      3'd3:    next_word = {TAG_STAT,  snap_status};
      default: next_word = {TAG_CSUM,  csum};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= GAP;
      gap_cnt         <= '0;
      word_idx        <= '0;
      snap_pl1_posy   <= '0;
      snap_ball_posx  <= '0;
      snap_ball_posy  <= '0;
      snap_status     <= '0;
      csum            <= '0;
      link.data       <= '0;
      link.data_valid <= 1'b0;
      link.frame_done <= 1'b0;
    end else begin
      link.frame_done <= 1'b0;
      case (state)
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= SNAP;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        SNAP: begin
          snap_pl1_posy   <= pl1_posy;
          snap_ball_posx  <= ball_posx;
          snap_ball_posy  <= ball_posy;
          snap_status     <= live_status;
          csum            <= live_sum;
          link.data       <= {TAG_PL1X, pl1_posx};
          link.data_valid <= 1'b1;
          word_idx        <= '0;
          state           <= SEND;
        end

        SEND: begin
          if (link.conv16to8ready) begin
            if (word_idx == LAST_IDX) begin
              link.data_valid <= 1'b0;
              link.frame_done <= 1'b1;
              word_idx        <= '0;
              gap_cnt         <= '0;
              state           <= GAP;
            end else begin
              word_idx  <= word_idx + 3'd1;
              link.data <= next_word;
            end
          end
        end

        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_mux.sv
// Scoreboard bench for game_state_mux: one instance with FRAME_GAP=4 and one with
// FRAME_GAP=0, a converter model pulsing ready, and expected words queued up front.
module tb_game_state_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game;

  game_state_mux_if link4();
  game_state_mux_if link0();

  game_state_mux #(.FRAME_GAP(4)) dut (
    .clk(clk), .rst(rst), .link(link4),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
    .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score),
    .flag_point(flag_point), .end_game(end_game)
  );

  game_state_mux #(.FRAME_GAP(0)) dut_gap0 (
    .clk(clk), .rst(rst), .link(link0),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
    .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score),
    .flag_point(flag_point), .end_game(end_game)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic set_inputs(input logic [11:0] px, input logic [11:0] py,
                            input logic [11:0] bx, input logic [11:0] by,
                            input logic [3:0] s1, input logic [3:0] s2,
                            input logic fp, input logic eg);
    pl1_posx = px; pl1_posy = py; ball_posx = bx; ball_posy = by;
    pl1_score = s1; pl2_score = s2; flag_point = fp; end_game = eg;
  endtask

  task automatic push_model();
    logic [11:0] st, sum;
    st  = {2'b00, flag_point, end_game, pl1_score, pl2_score};
    sum = pl1_posx + pl1_posy + ball_posx + ball_posy + st;
    exp_q.push_back({4'h1, pl1_posx});
    exp_q.push_back({4'h2, pl1_posy});
    exp_q.push_back({4'h3, ball_posx});
    exp_q.push_back({4'h4, ball_posy});
    exp_q.push_back({4'h5, st});
    exp_q.push_back({4'hF, sum});
  endtask

  task automatic apply_stimulus();
    set_inputs(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    push_model();
  endtask

  function automatic logic [15:0] obs_data(input bit sel);
    return sel ? link0.data : link4.data;
  endfunction

  function automatic logic obs_valid(input bit sel);
    return sel ? link0.data_valid : link4.data_valid;
  endfunction

  function automatic logic obs_done(input bit sel);
    return sel ? link0.frame_done : link4.frame_done;
  endfunction

  task automatic set_ready(input bit sel, input logic v);
    if (sel) link0.conv16to8ready = v;
    else     link4.conv16to8ready = v;
  endtask

  function automatic logic [15:0] pop_exp();
    return (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
  endfunction

  task automatic wait_valid_count(input bit sel, output int n);
    n = 0;
    while (obs_valid(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Converter model: wait for a word, let it sit for 'delay' cycles, then pulse ready once.
  task automatic converter_pulse(input bit sel, input int delay, output bit ok,
                                 output logic [15:0] first, output logic [15:0] held,
                                 output logic held_valid);
    int n;
    wait_valid_count(sel, n);
    ok    = (obs_valid(sel) === 1'b1);
    first = obs_data(sel);
    repeat (delay) @(negedge clk);
    held       = obs_data(sel);
    held_valid = obs_valid(sel);
    if (ok) begin
      set_ready(sel, 1'b1);
      @(negedge clk);
      set_ready(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (53) begin
      @(negedge clk);
      total++;
      if (link4.data !== 16'h0000 || link4.data_valid !== 1'b0 || link4.frame_done !== 1'b0 ||
          link0.data !== 16'h0000 || link0.data_valid !== 1'b0 || link0.frame_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: got data=%h/%h valid=%b/%b done=%b/%b want all zero",
                 link4.data, link0.data, link4.data_valid, link0.data_valid,
                 link4.frame_done, link0.frame_done);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok; logic [15:0] first, held, exp, last; logic hv; int n;
    exp_q.push_back(16'h1064); exp_q.push_back(16'h22A7); exp_q.push_back(16'h3200);
    exp_q.push_back(16'h412C); exp_q.push_back(16'h5235); exp_q.push_back(16'hF86C);
    // GAP spans FRAME_GAP+1 cycles, then one SNAP cycle before word 0 appears.
    wait_valid_count(1'b0, n);
    total++;
    if (n != 6) begin
      bad++;
      $display("[TB] FAIL nominal_latency: got %0d cycles want 6", n);
    end
    last = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      converter_pulse(1'b0, 20, ok, first, held, hv);
      exp = pop_exp();
      last = exp;
      total++;
      if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL nominal_word%0d: got %h (held %h valid %b) want %h", i, first, held, hv, exp);
      end
    end
    total++;
    if (link4.data_valid !== 1'b0 || link4.frame_done !== 1'b1 || link4.data !== last) begin
      bad++;
      $display("[TB] FAIL nominal_end: got valid=%b done=%b data=%h want 0/1/%h",
               link4.data_valid, link4.frame_done, link4.data, last);
    end
    @(negedge clk);
    total++;
    if (link4.frame_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nominal_done_width: got done=%b want 0", link4.frame_done);
    end
  endtask

  task automatic test_spurious_ready();
    set_ready(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (link4.data !== 16'hF86C || link4.data_valid !== 1'b0 || link4.frame_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL gap_ready%0d: got data=%h valid=%b done=%b want F86C/0/0",
                 i, link4.data, link4.data_valid, link4.frame_done);
      end
    end
    set_ready(1'b0, 1'b0);
  endtask

  task automatic test_checksum_wrap();
    bit ok; logic [15:0] first, held, exp, last; logic hv;
    set_inputs(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 1'b1, 1'b1);
    exp_q.push_back(16'h1FFF); exp_q.push_back(16'h2FFF); exp_q.push_back(16'h3FFF);
    exp_q.push_back(16'h4FFF); exp_q.push_back(16'h53FF); exp_q.push_back(16'hF3FB);
    last = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      converter_pulse(1'b0, 20, ok, first, held, hv);
      exp = pop_exp();
      last = exp;
      total++;
      if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wrap_word%0d: got %h (held %h valid %b) want %h", i, first, held, hv, exp);
      end
    end
    total++;
    if (link4.data_valid !== 1'b0 || link4.frame_done !== 1'b1 || link4.data !== last) begin
      bad++;
      $display("[TB] FAIL wrap_end: got valid=%b done=%b data=%h want 0/1/%h",
               link4.data_valid, link4.frame_done, link4.data, last);
    end
    @(negedge clk);
  endtask

  task automatic test_coherence();
    bit ok; logic [15:0] first, held, exp, last; logic hv; int n;
    set_inputs(12'd100, 12'd679, 12'd512, 12'd300, 4'd3, 4'd5, 1'b1, 1'b0);
    exp_q.push_back(16'h1064); exp_q.push_back(16'h22A7); exp_q.push_back(16'h3200);
    exp_q.push_back(16'h412C); exp_q.push_back(16'h5235); exp_q.push_back(16'hF86C);
    exp_q.push_back(16'h1064); exp_q.push_back(16'h22A7); exp_q.push_back(16'h3001);
    exp_q.push_back(16'h412C); exp_q.push_back(16'h5235); exp_q.push_back(16'hF66D);
    wait_valid_count(1'b0, n);
    ball_posx = 12'h001;
    for (int f = 0; f < 2; f++) begin
      last = 16'h0000;
      for (int i = 0; i < 6; i++) begin
        converter_pulse(1'b0, 20, ok, first, held, hv);
        exp = pop_exp();
        last = exp;
        total++;
        if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
          bad++;
          $display("[TB] FAIL coherence_f%0d_word%0d: got %h (held %h valid %b) want %h",
                   f, i, first, held, hv, exp);
        end
      end
      total++;
      if (link4.data_valid !== 1'b0 || link4.frame_done !== 1'b1 || link4.data !== last) begin
        bad++;
        $display("[TB] FAIL coherence_end%0d: got valid=%b done=%b data=%h want 0/1/%h",
                 f, link4.data_valid, link4.frame_done, link4.data, last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_held_ready();
    bit ok; logic [15:0] first, held; logic hv; int n;
    logic [15:0] w[6];
    apply_stimulus();
    for (int i = 0; i < 6; i++) w[i] = pop_exp();
    wait_valid_count(1'b0, n);
    total++;
    if (link4.data_valid !== 1'b1 || link4.data !== w[0]) begin
      bad++;
      $display("[TB] FAIL held_word0: got %h valid %b want %h", link4.data, link4.data_valid, w[0]);
    end
    set_ready(1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (link4.data_valid !== 1'b1 || link4.data !== w[k]) begin
        bad++;
        $display("[TB] FAIL held_step%0d: got %h valid %b want %h", k, link4.data, link4.data_valid, w[k]);
      end
    end
    set_ready(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if (link4.data_valid !== 1'b1 || link4.data !== w[3]) begin
      bad++;
      $display("[TB] FAIL held_stop: got %h valid %b want %h", link4.data, link4.data_valid, w[3]);
    end
    for (int k = 3; k < 6; k++) begin
      converter_pulse(1'b0, 20, ok, first, held, hv);
      total++;
      if (!ok || first !== w[k] || held !== w[k] || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL held_word%0d: got %h (held %h valid %b) want %h", k, first, held, hv, w[k]);
      end
    end
    total++;
    if (link4.data_valid !== 1'b0 || link4.frame_done !== 1'b1 || link4.data !== w[5]) begin
      bad++;
      $display("[TB] FAIL held_end: got valid=%b done=%b data=%h want 0/1/%h",
               link4.data_valid, link4.frame_done, link4.data, w[5]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit ok; logic [15:0] first, held, exp, last; logic hv; int n;
    apply_stimulus();
    for (int i = 0; i < 3; i++) begin
      converter_pulse(1'b0, 20, ok, first, held, hv);
      exp = pop_exp();
      total++;
      if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL midreset_pre%0d: got %h (held %h valid %b) want %h", i, first, held, hv, exp);
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (link4.data_valid !== 1'b0 || link4.data !== 16'h0000 || link4.frame_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_abort: got valid=%b data=%h done=%b want 0/0000/0",
               link4.data_valid, link4.data, link4.frame_done);
    end
    exp_q.delete();
    rst = 1'b0;
    apply_stimulus();
    wait_valid_count(1'b0, n);
    total++;
    if (n != 6) begin
      bad++;
      $display("[TB] FAIL midreset_restart: got %0d cycles want 6", n);
    end
    last = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      converter_pulse(1'b0, 20, ok, first, held, hv);
      exp = pop_exp();
      last = exp;
      total++;
      if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL midreset_word%0d: got %h (held %h valid %b) want %h", i, first, held, hv, exp);
      end
    end
    total++;
    if (link4.data_valid !== 1'b0 || link4.frame_done !== 1'b1 || link4.data !== last) begin
      bad++;
      $display("[TB] FAIL midreset_end: got valid=%b done=%b data=%h want 0/1/%h",
               link4.data_valid, link4.frame_done, link4.data, last);
    end
    @(negedge clk);
  endtask

  task automatic test_gap0();
    bit ok; logic [15:0] first, held, exp, last; logic hv; int n;
    rst = 1'b1;
    apply_stimulus();
    @(negedge clk);
    rst = 1'b0;
    wait_valid_count(1'b1, n);
    total++;
    if (n != 2) begin
      bad++;
      $display("[TB] FAIL gap0_latency: got %0d cycles want 2", n);
    end
    last = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      converter_pulse(1'b1, 3, ok, first, held, hv);
      exp = pop_exp();
      last = exp;
      total++;
      if (!ok || first !== exp || held !== exp || hv !== 1'b1) begin
        bad++;
        $display("[TB] FAIL gap0_word%0d: got %h (held %h valid %b) want %h", i, first, held, hv, exp);
      end
    end
    total++;
    if (obs_valid(1'b1) !== 1'b0 || obs_done(1'b1) !== 1'b1 || obs_data(1'b1) !== last) begin
      bad++;
      $display("[TB] FAIL gap0_end: got valid=%b done=%b data=%h want 0/1/%h",
               obs_valid(1'b1), obs_done(1'b1), obs_data(1'b1), last);
    end
    @(negedge clk);
    total++;
    if (obs_valid(1'b1) !== 1'b0 || obs_done(1'b1) !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gap0_snap: got valid=%b done=%b want 0/0", obs_valid(1'b1), obs_done(1'b1));
    end
    @(negedge clk);
    total++;
    if (obs_valid(1'b1) !== 1'b1 || obs_data(1'b1) !== {4'h1, pl1_posx}) begin
      bad++;
      $display("[TB] FAIL gap0_next_frame: got valid=%b data=%h want 1/%h",
               obs_valid(1'b1), obs_data(1'b1), {4'h1, pl1_posx});
    end
  endtask

  initial begin
    rst = 1'b1;
    link4.conv16to8ready = 1'b0;
    link0.conv16to8ready = 1'b0;
    set_inputs(12'd100, 12'd679, 12'd512, 12'd300, 4'd3, 4'd5, 1'b1, 1'b0);
    test_reset();
    test_nominal();
    test_spurious_ready();
    test_checksum_wrap();
    test_coherence();
    test_held_ready();
    test_reset_mid_frame();
    test_gap0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
